jk_seq_arbiter: RTL and testbench

JK_SEQ_ARBITER -- requirements
Module: jk_seq_arbiter

---
 rtl/jk_seq_arbiter_if.sv | 25 ++
 rtl/jk_seq_arbiter.sv | 116 +++++++++++
 tb/tb_jk_seq_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_seq_arbiter_if.sv
// Requester/flip-flop side signals of jk_seq_arbiter, bundled for a single port.
interface jk_seq_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] cmd;
  logic               ff_q;
  logic               j;
  logic               k;
  logic [N_REQ-1:0]   gnt;
  logic               done;
  logic               rd_q;
  logic               busy;
  logic               err;

  modport master (
    output req, cmd, ff_q,
    input  j, k, gnt, done, rd_q, busy, err
  );

  modport slave (
    input  req, cmd, ff_q,
    output j, k, gnt, done, rd_q, busy, err
  );
endinterface

// File: rtl/jk_seq_arbiter.sv
// Round-robin arbiter sharing one external JK flip-flop among N_REQ requesters:
// each grant drives j/k for one cycle, then samples q and checks it against a tracked value.
module jk_seq_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  jk_seq_arbiter_if.slave bus
);
  localparam int unsigned NU = N_REQ;
  localparam int unsigned PW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} state_t;
  typedef enum logic [1:0] {
    CMD_HOLD   = 2'b00,
    CMD_RESET  = 2'b01,
    CMD_SET    = 2'b10,
    CMD_TOGGLE = 2'b11
  } cmd_t;

  state_t           state, state_nxt;
  cmd_t             cmd_lat;
  logic [PW-1:0]    ptr, win, cand;
  logic [N_REQ-1:0] gnt_r;
  logic             rd_q_r, exp_valid, exp_q, err_r;
  logic             grant, in_drive, in_sample, new_exp, pinned, mismatch;

  always_comb begin
    win  = ptr;
    cand = ptr;
    // offsets visited from NU down to 1, so the last hit is the nearest index after ptr
    for (int unsigned i = 0; i < NU; i++) begin
      cand = PW'((32'(ptr) + NU - i) % NU);
      if (bus.req[cand]) win = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    in_drive  = 1'b0;
    in_sample = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          grant     = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        in_drive  = 1'b1;
        state_nxt = SAMPLE;
      end
      SAMPLE: begin
        in_sample = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Before any SET/RESET the absolute q is unknown, so HOLD/TOGGLE adopt the observed q.
  always_comb begin
    new_exp = exp_q;
    case (cmd_lat)
      CMD_HOLD:   new_exp = exp_valid ? exp_q : bus.ff_q;
      CMD_RESET:  new_exp = 1'b0;
      CMD_SET:    new_exp = 1'b1;
      CMD_TOGGLE: new_exp = exp_valid ? ~exp_q : bus.ff_q;
      default:    new_exp = exp_q;
    endcase
  end

  assign pinned   = (cmd_lat == CMD_SET) || (cmd_lat == CMD_RESET);
  assign mismatch = in_sample && (exp_valid || pinned) && (bus.ff_q != new_exp);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_r     <= '0;
      cmd_lat   <= CMD_HOLD;
      ptr       <= PW'(NU - 1);
      rd_q_r    <= 1'b0;
      exp_valid <= 1'b0;
      exp_q     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      if (grant) begin
        gnt_r   <= ONE << win;
        cmd_lat <= cmd_t'(bus.cmd[{win, 1'b0} +: 2]);
        ptr     <= win;
      end
      if (in_sample) begin
        gnt_r     <= '0;
        rd_q_r    <= bus.ff_q;
        exp_q     <= new_exp;
        exp_valid <= exp_valid | pinned;
        err_r     <= err_r | mismatch;
      end
    end
  end

  assign bus.j    = in_drive & cmd_lat[1];
  assign bus.k    = in_drive & cmd_lat[0];
  assign bus.gnt  = gnt_r;
  assign bus.done = in_sample;
  assign bus.busy = in_drive | in_sample;
  // the sampled value is visible alongside done, then held by the register
  assign bus.rd_q = in_sample ? bus.ff_q : rd_q_r;
  assign bus.err  = err_r | mismatch;
endmodule

// File: tb/tb_jk_seq_arbiter.sv
// Bench for jk_seq_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_jk_seq_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jk_seq_arbiter_if #(.N_REQ(N)) bus ();
  jk_seq_arbiter #(.N_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // external shared JK flip-flop, with an override to model a faulty readback
  logic ff_state  = 1'b0;
  logic force_en  = 1'b0;
  logic force_val = 1'b0;
  always @(posedge clk) begin
    case ({bus.j, bus.k})
      2'b10:   ff_state <= 1'b1;
      2'b01:   ff_state <= 1'b0;
      2'b11:   ff_state <= ~ff_state;
      default: ff_state <= ff_state;
    endcase
  end
  assign bus.ff_q = force_en ? force_val : ff_state;

  function automatic logic plant_q();
    return force_en ? force_val : ff_state;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic je, input logic ke,
                         input logic de, input logic be, input logic re, input logic ee);
    chk({tag, ".gnt"},  32'(bus.gnt),  32'(g));
    chk({tag, ".j"},    32'(bus.j),    32'(je));
    chk({tag, ".k"},    32'(bus.k),    32'(ke));
    chk({tag, ".done"}, 32'(bus.done), 32'(de));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(be));
    chk({tag, ".rd_q"}, 32'(bus.rd_q), 32'(re));
    chk({tag, ".err"},  32'(bus.err),  32'(ee));
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.cmd  = '0;
    force_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one full operation for a single requester; returns what was seen alongside done
  task automatic run_op(input int who, input logic [1:0] c, input logic fe, input logic fv,
                        output logic [3:0] g, output logic d, output logic rq, output logic e);
    bus.req = 4'(1 << who);
    bus.cmd = 8'(c) << (2 * who);
    @(negedge clk);
    bus.req   = '0;
    force_en  = fe;
    force_val = fv;
    @(negedge clk);
    g  = bus.gnt;
    d  = bus.done;
    rq = bus.rd_q;
    e  = bus.err;
    @(negedge clk);
    force_en = 1'b0;
  endtask

  // ---------------- reference model (operation level) ----------------
  bit          m_active, m_expv, m_expq, m_err, m_rdq;
  int          m_age;
  int unsigned m_ptr, m_who;
  bit [1:0]    m_cmd;

  task automatic model_reset();
    m_active = 0; m_age = 0; m_ptr = N - 1; m_who = 0; m_cmd = 0;
    m_rdq = 0; m_expv = 0; m_expq = 0; m_err = 0;
  endtask

  function automatic void eval_op(input bit [1:0] c, input bit q, output bit nq, output bit bad);
    bit absolute;
    absolute = (c == 2'b01) || (c == 2'b10);
    case (c)
      2'b00:   nq = m_expv ? m_expq : q;
      2'b01:   nq = 1'b0;
      2'b10:   nq = 1'b1;
      default: nq = m_expv ? !m_expq : q;
    endcase
    bad = (m_expv || absolute) && (q != nq);
  endfunction

  task automatic model_edge(input bit rn, input logic [3:0] r, input logic [7:0] c, input bit q);
    bit nq, bad, found;
    if (!rn) begin
      model_reset();
    end else if (!m_active) begin
      found = 0;
      for (int s = 1; s <= N; s++) begin
        if (!found && r[(m_ptr + s) % N]) begin
          m_who = (m_ptr + s) % N;
          found = 1;
        end
      end
      if (found) begin
        m_active = 1;
        m_age    = 0;
        m_cmd    = c[2 * m_who +: 2];
        m_ptr    = m_who;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else begin
      eval_op(m_cmd, q, nq, bad);
      if (bad) m_err = 1;
      m_rdq  = q;
      m_expq = nq;
      if (m_cmd == 2'b01 || m_cmd == 2'b10) m_expv = 1;
      m_active = 0;
      m_age    = 0;
    end
  endtask

  task automatic model_check();
    bit nq, bad, smp, drv;
    smp = m_active && m_age == 1;
    drv = m_active && m_age == 0;
    eval_op(m_cmd, plant_q(), nq, bad);
    chk_out("rnd", m_active ? 4'(1 << m_who) : 4'h0, drv && m_cmd[1], drv && m_cmd[0],
            smp, m_active, smp ? plant_q() : m_rdq, m_err | (smp & bad));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rn;
    logic [3:0] req;
    logic [7:0] cmd;
    logic       fe, fv;
    logic [3:0] gnt;
    logic       j, k, done, busy, rdq, err;
  } vec_t;

  vec_t tbl[15];

  logic [3:0] og;
  logic       od, orq, oe, q0;

  initial begin
    bus.req = '0;
    bus.cmd = '0;

    //            rn  req    cmd   fe fv  gnt    j  k  dn bsy rdq err
    tbl[0]  = '{1'b0, 4'h0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 4'h1, 8'h02, 0, 0, 4'h1, 1, 0, 0, 1, 0, 0};
    tbl[2]  = '{1'b1, 4'h1, 8'h02, 0, 0, 4'h1, 0, 0, 1, 1, 1, 0};
    tbl[3]  = '{1'b1, 4'h0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0};
    tbl[4]  = '{1'b0, 4'h0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1'b1, 4'h6, 8'h00, 0, 0, 4'h2, 0, 0, 0, 1, 0, 0};
    tbl[6]  = '{1'b1, 4'h6, 8'h00, 0, 0, 4'h2, 0, 0, 1, 1, 1, 0};
    tbl[7]  = '{1'b1, 4'h4, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0};
    tbl[8]  = '{1'b1, 4'h4, 8'h00, 0, 0, 4'h4, 0, 0, 0, 1, 1, 0};
    tbl[9]  = '{1'b1, 4'h0, 8'h00, 0, 0, 4'h4, 0, 0, 1, 1, 1, 0};
    tbl[10] = '{1'b1, 4'h0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0};
    tbl[11] = '{1'b1, 4'h1, 8'h00, 0, 0, 4'h1, 0, 0, 0, 1, 1, 0};
    tbl[12] = '{1'b1, 4'h0, 8'h00, 1, 0, 4'h1, 0, 0, 1, 1, 0, 0};
    tbl[13] = '{1'b1, 4'h0, 8'h00, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{1'b1, 4'h0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      rst_n     = tbl[i].rn;
      bus.req   = tbl[i].req;
      bus.cmd   = tbl[i].cmd;
      force_en  = tbl[i].fe;
      force_val = tbl[i].fv;
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].j, tbl[i].k,
              tbl[i].done, tbl[i].busy, tbl[i].rdq, tbl[i].err);
    end

    // all requesters with TOGGLE: rotating grants every 3 cycles, rd_q alternating
    do_reset();
    q0 = ff_state;
    bus.req = 4'hF;
    bus.cmd = 8'hFF;
    for (int op = 0; op < 5; op++) begin
      @(negedge clk);
      chk($sformatf("rr%0d.gnt", op), 32'(bus.gnt), 32'(1 << (op % N)));
      chk($sformatf("rr%0d.jk", op), 32'({bus.j, bus.k}), 32'h3);
      @(negedge clk);
      chk($sformatf("rr%0d.done", op), 32'(bus.done), 32'h1);
      chk($sformatf("rr%0d.rd_q", op), 32'(bus.rd_q), 32'(q0 ^ (op % 2 == 0)));
      chk($sformatf("rr%0d.err", op), 32'(bus.err), 32'h0);
      @(negedge clk);
      chk($sformatf("rr%0d.idle", op), 32'({bus.busy, bus.gnt}), 32'h0);
    end
    bus.req = '0;

    // requester 2 drops req while driven; next grant goes to 3
    do_reset();
    bus.req = 4'b0100;
    @(negedge clk);
    chk("drop.gnt_drive", 32'(bus.gnt), 32'h4);
    bus.req = 4'b1001;
    @(negedge clk);
    chk("drop.done", 32'(bus.done), 32'h1);
    chk("drop.gnt_sample", 32'(bus.gnt), 32'h4);
    @(negedge clk);
    chk("drop.idle", 32'({bus.busy, bus.gnt}), 32'h0);
    @(negedge clk);
    chk("drop.next_gnt", 32'(bus.gnt), 32'h8);
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);

    // sticky err after a corrupted readback
    do_reset();
    run_op(0, 2'b10, 0, 0, og, od, orq, oe);
    chk("err.set_rdq", 32'(orq), 32'h1);
    chk("err.set_err", 32'(oe), 32'h0);
    run_op(1, 2'b00, 1, 0, og, od, orq, oe);
    chk("err.hold_gnt", 32'(og), 32'h2);
    chk("err.hold_rdq", 32'(orq), 32'h0);
    chk("err.hold_err", 32'(oe), 32'h1);
    run_op(2, 2'b10, 0, 0, og, od, orq, oe);
    chk("err.sticky1", 32'(oe), 32'h1);
    run_op(3, 2'b11, 0, 0, og, od, orq, oe);
    chk("err.sticky2", 32'(oe), 32'h1);
    chk("err.tgl_rdq", 32'(orq), 32'h0);
    chk("err.idle_err", 32'(bus.err), 32'h1);
    do_reset();
    chk("err.cleared", 32'(bus.err), 32'h0);

    // reset while driving aborts the operation
    bus.req = 4'b0010;
    bus.cmd = 8'b0000_1000;
    @(negedge clk);
    chk_out("abort_drive", 4'b0010, 1, 0, 0, 1, 0, 0);
    rst_n   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    chk_out("abort_rst", 4'h0, 0, 0, 0, 0, 0, 0);
    rst_n   = 1'b1;
    bus.req = 4'b1100;
    bus.cmd = '0;
    @(negedge clk);
    chk_out("abort_regrant", 4'b0100, 0, 0, 0, 1, 0, 0);
    bus.req = '0;
    @(negedge clk);
    chk_out("abort_sample", 4'b0100, 0, 0, 1, 1, 1, 0);
    @(negedge clk);

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      if (!(m_active && m_age == 1)) begin
        force_en  = m_active && m_age == 0 && ($urandom_range(0, 5) == 0);
        force_val = 1'($urandom_range(0, 1));
      end
      rst_n   = ($urandom_range(0, 63) != 0);
      bus.req = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      bus.cmd = 8'($urandom);
      model_edge(rst_n, bus.req, bus.cmd, plant_q());
      @(negedge clk);
      model_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
